// File: rtl/cache_req_queue_pkg.sv
// +--------------------------------------------------------------------+
// | dram_cache_pkg: shared entry type, AR FSM states, entry constants  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package dram_cache_pkg;

  localparam int ENTRY_W     = 81;
  localparam int LINE_OFFSET = 6;

  typedef struct packed {
    logic        wr;
    logic [15:0] id;
    logic [63:0] addr;
  } req_entry_t;

  typedef enum logic [0:0] {
    AR_IDLE = 1'b0,
    AR_WAIT = 1'b1
  } ar_state_t;

endpackage

`default_nettype wire

// File: rtl/cache_req_queue_if.sv
// +--------------------------------------------------------------------+
// | cache_req_queue_if: host request, AR tag-read and head ports       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface cache_req_queue_if
  import dram_cache_pkg::*;
#(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               req_valid_i;
  logic               req_ready_o;
  logic               req_wr_i;
  logic [15:0]        req_id_i;
  logic [63:0]        req_addr_i;
  logic               arvalid_o;
  logic               arready_i;
  logic [63:0]        araddr_o;
  logic [ENTRY_W-1:0] fifo_data_o;
  logic               head_valid_o;
  logic               head_pop_i;
  logic [CW-1:0]      count_o;

  modport slave (
    input  req_valid_i, req_wr_i, req_id_i, req_addr_i, arready_i, head_pop_i,
    output req_ready_o, arvalid_o, araddr_o, fifo_data_o, head_valid_o, count_o
  );

  modport master (
    output req_valid_i, req_wr_i, req_id_i, req_addr_i, arready_i, head_pop_i,
    input  req_ready_o, arvalid_o, araddr_o, fifo_data_o, head_valid_o, count_o
  );

endinterface

`default_nettype wire

// File: rtl/cache_req_queue_ptr_fifo.sv
// +--------------------------------------------------------------------+
// | req_ptr_fifo: entry storage with wrap-bit wr/rd pointers           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module req_ptr_fifo
  import dram_cache_pkg::*;
#(
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          i_push,
  input  req_entry_t         i_data,
  input  wire logic          i_pop,
  input  wire logic [PW-1:0] i_peek_ptr,
  output req_entry_t         o_rd_data,
  output req_entry_t         o_peek_data,
  output logic      [PW-1:0] o_wr_ptr,
  output logic      [PW-1:0] o_rd_ptr,
  output logic      [PW-1:0] o_count,
  output logic               o_full
);

  req_entry_t        r_mem [DEPTH];
  logic     [PW-1:0] r_wr_ptr;
  logic     [PW-1:0] r_rd_ptr;

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + PW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  assign o_rd_data   = r_mem[r_rd_ptr[AW-1:0]];
  assign o_peek_data = r_mem[i_peek_ptr[AW-1:0]];
  assign o_wr_ptr    = r_wr_ptr;
  assign o_rd_ptr    = r_rd_ptr;
  assign o_count     = r_wr_ptr - r_rd_ptr;
  assign o_full      = (o_count == PW'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/cache_req_queue.sv
// +--------------------------------------------------------------------+
// | cache_req_queue: request queue issuing in-order AR tag lookups     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module cache_req_queue
  import dram_cache_pkg::*;
#(
  parameter int          DEPTH        = 8,
  parameter int          TAG_BIT_SIZE = 8,
  parameter int          INDEX_BITS   = 10,
  parameter logic [63:0] TAG_BASE     = 64'h0000_0001_0000_0000
) (
  input wire logic       clk,
  input wire logic       rst_n,
  cache_req_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TAG_BIT_SIZE < 1 ||
      INDEX_BITS < 1 || LINE_OFFSET + INDEX_BITS > 64) begin : g_param_check
    $error("cache_req_queue: illegal parameter combination");
  end

  req_entry_t           w_push_entry;
  req_entry_t           w_head_entry;
  req_entry_t           w_ar_entry;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_head_valid;
  logic [PW-1:0]        w_wr_ptr;
  logic [PW-1:0]        w_rd_ptr;
  logic [PW-1:0]        w_count;
  logic [INDEX_BITS-1:0] w_ar_index;
  logic [63:0]          w_ar_addr;
  logic                 w_unused_entry;

  ar_state_t            r_state;
  logic [PW-1:0]        r_ar_ptr;
  logic                 r_arvalid;
  logic [63:0]          r_araddr;

  assign w_push_entry = '{wr: bus.req_wr_i, id: bus.req_id_i, addr: bus.req_addr_i};
  assign w_push       = bus.req_valid_i && !w_full;
  assign w_head_valid = (w_rd_ptr != r_ar_ptr);
  assign w_pop        = bus.head_pop_i && w_head_valid;

  req_ptr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_data      (w_push_entry),
    .i_pop       (w_pop),
    .i_peek_ptr  (r_ar_ptr),
    .o_rd_data   (w_head_entry),
    .o_peek_data (w_ar_entry),
    .o_wr_ptr    (w_wr_ptr),
    .o_rd_ptr    (w_rd_ptr),
    .o_count     (w_count),
    .o_full      (w_full)
  );

  // Each tag slot is 8 bytes, indexed by the set bits of the line address.
  assign w_ar_index     = w_ar_entry.addr[LINE_OFFSET+INDEX_BITS-1:LINE_OFFSET];
  assign w_ar_addr      = TAG_BASE + ({{(64-INDEX_BITS){1'b0}}, w_ar_index} << 3);
  assign w_unused_entry = ^{w_ar_entry.wr, w_ar_entry.id, w_ar_entry.addr};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= AR_IDLE;
      r_ar_ptr  <= '0;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
    end else begin
      case (r_state)
        AR_IDLE: begin
          if (r_ar_ptr != w_wr_ptr) begin
            r_araddr  <= w_ar_addr;
            r_arvalid <= 1'b1;
            r_state   <= AR_WAIT;
          end
        end
        AR_WAIT: begin
          // Returning through IDLE gives the bubble between consecutive ARs.
          if (bus.arready_i) begin
            r_arvalid <= 1'b0;
            r_ar_ptr  <= r_ar_ptr + PW'(1);
            r_state   <= AR_IDLE;
          end
        end
        default: begin
          r_arvalid <= 1'b0;
          r_state   <= AR_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o  = !w_full;
  assign bus.arvalid_o    = r_arvalid;
  assign bus.araddr_o     = r_araddr;
  assign bus.fifo_data_o  = w_head_entry;
  assign bus.head_valid_o = w_head_valid;
  assign bus.count_o      = w_count;

endmodule

`default_nettype wire

// File: tb/tb_cache_req_queue.sv
// +--------------------------------------------------------------------+
// | tb_cache_req_queue: randomized bench against a queue-based model   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_cache_req_queue;
  import dram_cache_pkg::*;

  localparam int          DEPTH      = 8;
  localparam int          INDEX_BITS = 10;
  localparam logic [63:0] TAG_BASE   = 64'h0000_0001_0000_0000;

  logic clk;
  logic rst_n;

  cache_req_queue_if #(.DEPTH(DEPTH)) bus ();

  cache_req_queue #(
    .DEPTH        (DEPTH),
    .TAG_BIT_SIZE (8),
    .INDEX_BITS   (INDEX_BITS),
    .TAG_BASE     (TAG_BASE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: every accepted request is logged in order; three counters say how
  // many were pushed, had their AR accepted, and were consumed.
  logic [80:0] hist[$];
  int          pushed;
  int          issued;
  int          popped;
  bit          fresh;
  bit          m_arvalid;
  logic [63:0] m_araddr;

  logic [63:0] last_araddr;
  logic [80:0] last_head;

  task automatic chk(input string tag, input logic [80:0] got, input logic [80:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    hist.delete();
    pushed    = 0;
    issued    = 0;
    popped    = 0;
    fresh     = 1'b1;
    m_arvalid = 1'b0;
    m_araddr  = '0;
  endtask

  task automatic cyc(input bit rst, input bit pv, input bit wr, input logic [15:0] id,
                     input logic [63:0] addr, input bit ardy, input bit pop);
    bit          do_push, do_pop, do_hs, do_issue;
    logic [63:0] a;
    rst_n           = !rst;
    bus.req_valid_i = pv;
    bus.req_wr_i    = wr;
    bus.req_id_i    = id;
    bus.req_addr_i  = addr;
    bus.arready_i   = ardy;
    bus.head_pop_i  = pop;
    @(negedge clk);
    chk("req_ready", bus.req_ready_o, (pushed - popped) < DEPTH);
    chk("count", bus.count_o, pushed - popped);
    chk("head_valid", bus.head_valid_o, issued > popped);
    chk("arvalid", bus.arvalid_o, m_arvalid);
    chk("araddr", bus.araddr_o, m_araddr);
    if (pushed > popped) chk("fifo_data", bus.fifo_data_o, hist[popped]);
    else if (fresh) chk("fifo_data_zero", bus.fifo_data_o, '0);
    if (bus.arvalid_o) last_araddr = bus.araddr_o;
    if (bus.head_valid_o) last_head = bus.fifo_data_o;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      do_push  = pv && ((pushed - popped) < DEPTH);
      do_pop   = pop && (issued > popped);
      do_hs    = m_arvalid && ardy;
      do_issue = !m_arvalid && (pushed > issued);
      if (do_issue) begin
        a         = hist[issued][63:0];
        m_araddr  = TAG_BASE + (64'(a[6+INDEX_BITS-1:6]) * 8);
        m_arvalid = 1'b1;
      end
      if (do_hs) begin
        issued++;
        m_arvalid = 1'b0;
      end
      if (do_pop) popped++;
      if (do_push) begin
        hist.push_back({wr, id, addr});
        pushed++;
        fresh = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input bit ardy);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, '0, ardy, 0);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_wr_i    = 1'b0;
    bus.req_id_i    = '0;
    bus.req_addr_i  = '0;
    bus.arready_i   = 1'b0;
    bus.head_pop_i  = 1'b0;
    last_araddr     = '0;
    last_head       = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // 1: single read, latency and tag address
    cyc(1, 0, 0, '0, '0, 0, 0);
    cyc(0, 1, 0, 16'h0001, 64'h0000_0000_0000_1240, 1, 0);
    idle(4, 1);
    chk("t1_araddr", last_araddr, 64'h0000_0001_0000_0248);
    chk("t1_head", last_head, {1'b0, 16'h0001, 64'h1240});

    // 2: fill with AR stalled
    cyc(1, 0, 0, '0, '0, 0, 0);
    for (int i = 0; i < DEPTH; i++)
      cyc(0, 1, i[0], 16'(16'h0100 + i), {32'h0, $urandom}, 0, 0);
    idle(3, 0);
    chk("t2_count", bus.count_o, DEPTH);

    // 3: full, pop and push together
    cyc(0, 0, 0, '0, '0, 1, 0);
    cyc(0, 1, 1, 16'hBEEF, 64'h0000_0000_0000_FFC0, 0, 1);
    cyc(0, 0, 0, '0, '0, 0, 0);
    chk("t3_count", bus.count_o, DEPTH - 1);
    chk("t3_ready", bus.req_ready_o, 1'b1);

    // 4: randomized traffic with stalls, wraps pointers many times
    for (int i = 0; i < 400; i++)
      cyc(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1), 16'($urandom),
          {$urandom, $urandom}, ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0));
    idle(4, 1);
    for (int i = 0; i < 3 * DEPTH; i++) cyc(0, 0, 0, '0, '0, 1, 1);

    // 5: pop with nothing issued
    cyc(1, 0, 0, '0, '0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, '0, '0, 0, 1);
    cyc(0, 1, 0, 16'h0055, 64'h0000_0000_0000_0040, 0, 1);
    cyc(0, 0, 0, '0, '0, 0, 1);
    idle(2, 0);

    // 6: reset while an AR is waiting
    cyc(1, 0, 0, '0, '0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 16'(i), {32'h0, $urandom}, 0, 0);
    idle(2, 0);
    cyc(1, 0, 0, '0, '0, 0, 0);
    idle(2, 0);
    chk("t6_arvalid", bus.arvalid_o, 1'b0);
    chk("t6_count", bus.count_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
